// File: rtl/rtc_read_sequencer.sv
// Reads the eleven RTC time/timer registers over the multiplexed address/data bus,
// converts each BCD value to binary and replays the results to the display during blanking.
module rtc_read_sequencer #(
    parameter int unsigned T_PHASE = 4,
    parameter int unsigned PRE_PAD = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stream_en,
    input  logic [7:0] ad_in,
    output logic [7:0] ad_out,
    output logic       ad_oe,
    output logic       cs_n,
    output logic       rd_n,
    output logic       wr_n,
    output logic       ad_n,
    output logic [7:0] dato_rtc,
    output logic       inicio_secuencia,
    output logic       busy,
    output logic       bcd_err
);

    localparam int unsigned NUM_REGS   = 11;
    localparam int unsigned YEAR_IDX   = 5;
    localparam int unsigned STREAM_LEN = PRE_PAD + NUM_REGS;
    localparam int unsigned SCNT_W     = $clog2(STREAM_LEN + 1);

    localparam logic [3:0]        PHASE_LAST  = 4'(T_PHASE - 1);
    localparam logic [3:0]        INDEX_LAST  = 4'(NUM_REGS - 1);
    localparam logic [SCNT_W-1:0] STREAM_LAST = SCNT_W'(STREAM_LEN - 1);
    localparam logic [SCNT_W-1:0] PAD_LEN     = SCNT_W'(PRE_PAD);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_GAP1, S_READ, S_GAP2, S_CONV, S_WAIT_EN, S_STREAM
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        phase_q, phase_d;
    logic [3:0]        index_q, index_d;
    logic [SCNT_W-1:0] scnt_q, scnt_d;
    logic [7:0]        raw_q;
    logic              bcd_err_q;
    logic [7:0]        buf_q [NUM_REGS];

    logic       phase_last;
    logic [7:0] masked;
    logic       nib_bad;
    logic [7:0] bin_val;

    function automatic logic [7:0] reg_addr(input logic [3:0] idx);
        logic [7:0] a;
        unique case (idx)
            4'd0:    a = 8'h21;
            4'd1:    a = 8'h22;
            4'd2:    a = 8'h23;
            4'd3:    a = 8'h24;
            4'd4:    a = 8'h25;
            4'd5:    a = 8'h26;
            4'd6:    a = 8'h27;
            4'd7:    a = 8'h28;
            4'd8:    a = 8'h41;
            4'd9:    a = 8'h42;
            4'd10:   a = 8'h43;
            default: a = 8'h00;
        endcase
        return a;
    endfunction

    assign phase_last = (phase_q == PHASE_LAST);

    // The year register keeps bit 7; the others carry control flags there.
    always_comb begin
        masked  = (index_q == 4'(YEAR_IDX)) ? raw_q : (raw_q & 8'h7F);
        nib_bad = (masked[7:4] > 4'd9) || (masked[3:0] > 4'd9);
        bin_val = nib_bad ? 8'hFF
                          : (({4'd0, masked[7:4]} * 8'd10) + {4'd0, masked[3:0]});
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            phase_q   <= '0;
            index_q   <= '0;
            scnt_q    <= '0;
            raw_q     <= '0;
            bcd_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            index_q <= index_d;
            scnt_q  <= scnt_d;
            if (state_q == S_READ && phase_last) begin
                raw_q <= ad_in;
            end
            if (state_q == S_IDLE && start) begin
                bcd_err_q <= 1'b0;
            end else if (state_q == S_CONV && nib_bad) begin
                bcd_err_q <= 1'b1;
            end
        end
    end

    // NOTE: the result buffer is reset explicitly because a defined all-zero
    // replay is required before the first completed read sequence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                buf_q[i] <= '0;
            end
        end else if (state_q == S_CONV) begin
            buf_q[index_q] <= bin_val;
        end
    end

    // NOTE: every signal assigned here gets a default first, so no latch can be inferred.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        index_d = index_q;
        scnt_d  = scnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ADDR;
                    phase_d = '0;
                    index_d = '0;
                end
            end
            S_ADDR, S_GAP1, S_READ, S_GAP2: begin
                if (phase_last) begin
                    phase_d = '0;
                    unique case (state_q)
                        S_ADDR:  state_d = S_GAP1;
                        S_GAP1:  state_d = S_READ;
                        S_READ:  state_d = S_GAP2;
                        default: state_d = S_CONV;
                    endcase
                end else begin
                    phase_d = phase_q + 4'd1;
                end
            end
            S_CONV: begin
                phase_d = '0;
                if (index_q == INDEX_LAST) begin
                    state_d = S_WAIT_EN;
                end else begin
                    index_d = index_q + 4'd1;
                    state_d = S_ADDR;
                end
            end
            S_WAIT_EN: begin
                if (stream_en) begin
                    state_d = S_STREAM;
                    scnt_d  = '0;
                end
            end
            S_STREAM: begin
                if (scnt_q == STREAM_LAST) begin
                    state_d = S_IDLE;
                    scnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from registered state, so reset releases the bus at once.
    always_comb begin
        cs_n             = 1'b1;
        rd_n             = 1'b1;
        wr_n             = 1'b1;
        ad_n             = 1'b1;
        ad_oe            = 1'b0;
        ad_out           = 8'h00;
        dato_rtc         = 8'h00;
        inicio_secuencia = 1'b0;
        unique case (state_q)
            S_ADDR: begin
                cs_n   = 1'b0;
                ad_n   = 1'b0;
                wr_n   = 1'b0;
                ad_oe  = 1'b1;
                ad_out = reg_addr(index_q);
            end
            S_GAP1: begin
                ad_oe  = (phase_q == 4'd0);
                ad_out = (phase_q == 4'd0) ? reg_addr(index_q) : 8'h00;
            end
            S_READ: begin
                cs_n = 1'b0;
                rd_n = 1'b0;
            end
            S_STREAM: begin
                inicio_secuencia = 1'b1;
                if (scnt_q >= PAD_LEN) begin
                    dato_rtc = buf_q[4'(scnt_q - PAD_LEN)];
                end
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != S_IDLE);
    assign bcd_err = bcd_err_q;

endmodule
